// File: rtl/mctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, state encoding,
// control-line codes and the decoded instruction class.
package mctrl_pkg;

    // Link register written by jal (selected by regDesCtrl = DES_RA)
    localparam logic [4:0] RA_IDX = 5'd31;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;

    localparam logic [1:0] DES_RT = 2'b00;
    localparam logic [1:0] DES_RD = 2'b01;
    localparam logic [1:0] DES_RA = 2'b11;

    localparam logic [1:0] DATA_DM  = 2'b00;
    localparam logic [1:0] DATA_ALU = 2'b01;
    localparam logic [1:0] DATA_PC4 = 2'b11;

    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_JAL = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;

    // One-hot instruction class; exactly one field is set for any instr
    typedef struct packed {
        logic r_add;
        logic r_sub;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic nop;
        logic ill;
    } instr_class_t;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       us_ext;
    } alu_cfg_t;

    // ALU operation and B-operand selection, held from EXEC through WB
    function automatic alu_cfg_t alu_cfg(input instr_class_t cls);
        alu_cfg_t cfg;
        cfg = '{alu_ctrl: ALU_ADD, alu_src: 1'b0, us_ext: 1'b0};
        if (cls.r_sub || cls.beq) cfg.alu_ctrl = ALU_SUB;
        if (cls.ori)              cfg = '{alu_ctrl: ALU_OR,  alu_src: 1'b1, us_ext: 1'b1};
        if (cls.lui)              cfg = '{alu_ctrl: ALU_LUI, alu_src: 1'b1, us_ext: 1'b0};
        if (cls.lw || cls.sw)     cfg = '{alu_ctrl: ALU_ADD, alu_src: 1'b1, us_ext: 1'b0};
        return cfg;
    endfunction

endpackage

// File: rtl/mctrl_decode.sv
// Combinational classifier: instruction word -> one-hot instruction class.
// The all-zero word is nop; every unsupported opcode/funct is ill.
module mctrl_decode
    import mctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls
);

    logic [5:0] op;
    logic [5:0] fn;

    assign op = instr[31:26];
    assign fn = instr[5:0];

    always_comb begin
        // NOTE: the whole struct is cleared first so every path through the case
        // assigns it; a missing default here would infer a latch.
        cls = '0;
        case (op)
            OP_RTYPE: begin
                if (instr == 32'h0) begin
                    cls.nop = 1'b1;
                end else begin
                    case (fn)
                        FN_ADD:  cls.r_add = 1'b1;
                        FN_SUB:  cls.r_sub = 1'b1;
                        FN_JR:   cls.jr    = 1'b1;
                        default: cls.ill   = 1'b1;
                    endcase
                end
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.ill = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory ready handshakes.
// Define MCTRL_ILLEGAL_TRAP_EN to halt on unknown encodings instead of skipping them.
module multicycle_ctrl
    import mctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        imem_rdy,
    input  logic        dm_rdy,
    output logic [2:0]  aluCtrl,
    output logic [1:0]  regDesCtrl,
    output logic [1:0]  regDataCtrl,
    output logic [2:0]  nextPCop,
    output logic        aluSrc,
    output logic        usExt,
    output logic        regWE,
    output logic        dmWE,
    output logic        dmRE,
    output logic        irWE,
    output logic        pcWE,
    output logic        retire,
    output logic        illegal
);

    state_t       state;
    instr_class_t cls;
    alu_cfg_t     cfg;
    logic         trap;
    logic         skip;
    logic         unused_zero;

    mctrl_decode u_decode (
        .instr (instr),
        .cls   (cls)
    );

    assign cfg = alu_cfg(cls);

    // Branch resolution happens in the datapath's PC mux, not here
    assign unused_zero = zero;

`ifdef MCTRL_ILLEGAL_TRAP_EN
    assign trap    = cls.ill;
    assign skip    = cls.nop;
    assign illegal = !reset && (state == S_HALT);
`else
    assign trap    = 1'b0;
    assign skip    = cls.nop | cls.ill;
    assign illegal = 1'b0;
`endif

    // NOTE: state is sequential, so it is written only with non-blocking
    // assignments; blocking here would race with readers on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_rdy) state <= S_DECODE;
                end
                S_DECODE: begin
                    if (trap)         state <= S_HALT;
                    else if (skip)    state <= S_FETCH;
                    else if (cls.jal) state <= S_WB;
                    else              state <= S_EXEC;
                end
                S_EXEC: begin
                    if (cls.lw || cls.sw)       state <= S_MEM;
                    else if (cls.beq || cls.jr) state <= S_FETCH;
                    else                        state <= S_WB;
                end
                S_MEM: begin
                    if (dm_rdy) state <= cls.lw ? S_WB : S_FETCH;
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Reset forces every line low immediately, independent of state
    always_comb begin
        aluCtrl     = ALU_ADD;
        regDesCtrl  = DES_RT;
        regDataCtrl = DATA_DM;
        nextPCop    = NPC_SEQ;
        aluSrc      = 1'b0;
        usExt       = 1'b0;
        regWE       = 1'b0;
        dmWE        = 1'b0;
        dmRE        = 1'b0;
        irWE        = 1'b0;
        pcWE        = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH:  irWE = imem_rdy;
                S_DECODE: pcWE = skip;
                S_EXEC: begin
                    {aluCtrl, aluSrc, usExt} = cfg;
                    if (cls.beq) begin
                        nextPCop = NPC_BEQ;
                        pcWE     = 1'b1;
                    end
                    if (cls.jr) begin
                        nextPCop = NPC_JR;
                        pcWE     = 1'b1;
                    end
                end
                S_MEM: begin
                    {aluCtrl, aluSrc, usExt} = cfg;
                    dmRE = cls.lw;
                    dmWE = cls.sw;
                    pcWE = cls.sw & dm_rdy;
                end
                S_WB: begin
                    {aluCtrl, aluSrc, usExt} = cfg;
                    regWE = 1'b1;
                    pcWE  = 1'b1;
                    if (cls.jal) begin
                        regDesCtrl  = DES_RA;
                        regDataCtrl = DATA_PC4;
                        nextPCop    = NPC_JAL;
                    end else if (cls.lw) begin
                        regDesCtrl  = DES_RT;
                        regDataCtrl = DATA_DM;
                    end else if (cls.ori || cls.lui) begin
                        regDesCtrl  = DES_RT;
                        regDataCtrl = DATA_ALU;
                    end else begin
                        regDesCtrl  = DES_RD;
                        regDataCtrl = DATA_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

    assign retire = pcWE;

    a_one_write: assert property (@(posedge clk) disable iff (reset) !(regWE && dmWE));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction
// phase model built from the instruction class and the memory wait counts.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        imem_rdy;
    logic        dm_rdy;
    logic [2:0]  aluCtrl;
    logic [1:0]  regDesCtrl;
    logic [1:0]  regDataCtrl;
    logic [2:0]  nextPCop;
    logic        aluSrc, usExt, regWE, dmWE, dmRE, irWE, pcWE, retire, illegal;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .zero        (zero),
        .imem_rdy    (imem_rdy),
        .dm_rdy      (dm_rdy),
        .aluCtrl     (aluCtrl),
        .regDesCtrl  (regDesCtrl),
        .regDataCtrl (regDataCtrl),
        .nextPCop    (nextPCop),
        .aluSrc      (aluSrc),
        .usExt       (usExt),
        .regWE       (regWE),
        .dmWE        (dmWE),
        .dmRE        (dmRE),
        .irWE        (irWE),
        .pcWE        (pcWE),
        .retire      (retire),
        .illegal     (illegal)
    );

    typedef enum int {C_ADD, C_SUB, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_NOP, C_ILL} cls_e;

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] des;
        logic [1:0] dat;
        logic [2:0] npc;
        logic src, ext, rwe, dwe, dre, ire, pwe, ret, ill;
    } ctl_t;

    typedef struct {
        logic imem;
        logic dm;
        ctl_t exp;
    } step_t;

    ctl_t  obs;
    step_t trace[$];

    assign obs = {aluCtrl, regDesCtrl, regDataCtrl, nextPCop, aluSrc, usExt,
                  regWE, dmWE, dmRE, irWE, pcWE, retire, illegal};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] make_instr(input cls_e c);
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] tgt;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        tgt = 26'($urandom);
        case (c)
            C_ADD: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            C_SUB: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            C_JR:  return {6'h00, rs, 15'd0, 6'h08};
            C_ORI: return {6'h0D, rs, rt, imm};
            C_LUI: return {6'h0F, 5'd0, rt, imm};
            C_LW:  return {6'h23, rs, rt, imm};
            C_SW:  return {6'h2B, rs, rt, imm};
            C_BEQ: return {6'h04, rs, rt, imm};
            C_JAL: return {6'h03, tgt};
            C_NOP: return 32'h0;
            default: begin
                case ($urandom_range(0, 3))
                    0:       return {6'h3F, tgt};
                    1:       return {6'h02, tgt};
                    2:       return {6'h00, rs, rt, rd, 5'd0, 6'h25};
                    default: return {6'h08, rs, rt, imm};
                endcase
            end
        endcase
    endfunction

    // Cycles from first FETCH to retire with both memories always ready
    function automatic int base_latency(input cls_e c);
        case (c)
            C_NOP, C_ILL:        return 2;
            C_BEQ, C_JR, C_JAL:  return 3;
            C_LW:                return 5;
            default:             return 4;
        endcase
    endfunction

    function automatic void push(input logic imem, input logic dm, input ctl_t e);
        step_t s;
        s.imem = imem;
        s.dm   = dm;
        s.exp  = e;
        trace.push_back(s);
    endfunction

    // Expected per-cycle control lines for one instruction
    function automatic void build(input cls_e c, input int fwait, input int mwait);
        ctl_t z, a, e;
        trace.delete();
        z = '0;
        a = '0;
        case (c)
            C_SUB, C_BEQ: a.alu = 3'b001;
            C_ORI:        begin a.alu = 3'b010; a.src = 1'b1; a.ext = 1'b1; end
            C_LUI:        begin a.alu = 3'b100; a.src = 1'b1; end
            C_LW, C_SW:   a.src = 1'b1;
            default: ;
        endcase

        for (int i = 0; i < fwait; i++) push(1'b0, 1'($urandom), z);
        e = z; e.ire = 1'b1;
        push(1'b1, 1'($urandom), e);

`ifdef MCTRL_ILLEGAL_TRAP_EN
        if (c == C_ILL) begin
            push(1'($urandom), 1'($urandom), z);
            e = z; e.ill = 1'b1;
            for (int i = 0; i < 3; i++) push(1'($urandom), 1'($urandom), e);
            return;
        end
`endif
        e = z;
        if (c == C_NOP || c == C_ILL) begin e.pwe = 1'b1; e.ret = 1'b1; end
        push(1'($urandom), 1'($urandom), e);
        if (c == C_NOP || c == C_ILL) return;

        if (c != C_JAL) begin
            e = a;
            if (c == C_BEQ) begin e.npc = 3'b001; e.pwe = 1'b1; e.ret = 1'b1; end
            if (c == C_JR)  begin e.npc = 3'b011; e.pwe = 1'b1; e.ret = 1'b1; end
            push(1'($urandom), 1'($urandom), e);
            if (c == C_BEQ || c == C_JR) return;
        end

        if (c == C_LW || c == C_SW) begin
            e = a;
            e.dre = (c == C_LW);
            e.dwe = (c == C_SW);
            for (int i = 0; i < mwait; i++) push(1'($urandom), 1'b0, e);
            if (c == C_SW) begin e.pwe = 1'b1; e.ret = 1'b1; end
            push(1'($urandom), 1'b1, e);
            if (c == C_SW) return;
        end

        e = a;
        e.rwe = 1'b1; e.pwe = 1'b1; e.ret = 1'b1;
        case (c)
            C_JAL:        begin e.des = 2'b11; e.dat = 2'b11; e.npc = 3'b010; end
            C_LW:         begin e.des = 2'b00; e.dat = 2'b00; end
            C_ORI, C_LUI: begin e.des = 2'b00; e.dat = 2'b01; end
            default:      begin e.des = 2'b01; e.dat = 2'b01; end
        endcase
        push(1'($urandom), 1'($urandom), e);
    endfunction

    // Entered at posedge+1; expect_ret >= 0 checks the retire cycle, -1 checks
    // that no retire happens, -2 skips the retire checks (truncated run)
    task automatic run_trace(input string name, input int expect_ret, input int max_cycles);
        int ret_at = -1;
        int n_ret  = 0;
        for (int i = 0; i < trace.size() && i < max_cycles; i++) begin
            imem_rdy = trace[i].imem;
            dm_rdy   = trace[i].dm;
            zero     = 1'($urandom);
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, i), 32'(obs), 32'(trace[i].exp));
            if (retire) begin
                n_ret++;
                if (ret_at < 0) ret_at = i;
            end
            @(posedge clk);
            #1;
        end
        if (expect_ret >= 0) begin
            check({name, " retire_cycle"}, ret_at, expect_ret);
            check({name, " retire_count"}, n_ret, 1);
        end else if (expect_ret == -1) begin
            check({name, " no_retire"}, n_ret, 0);
        end
    endtask

    task automatic run_instr(input string name, input cls_e c, input logic [31:0] ins,
                             input int fwait, input int mwait);
        int exp_ret;
        instr = ins;
        build(c, fwait, mwait);
        exp_ret = fwait + base_latency(c) - 1 + ((c == C_LW || c == C_SW) ? mwait : 0);
`ifdef MCTRL_ILLEGAL_TRAP_EN
        if (c == C_ILL) exp_ret = -1;
`endif
        run_trace(name, exp_ret, 1000);
    endtask

    // Entered and left at posedge+1 with the controller idle in FETCH
    task automatic do_reset(input string name);
        ctl_t e;
        imem_rdy = 1'b1;
        dm_rdy   = 1'b1;
        reset    = 1'b1;
        #1;
        check({name, " outs_async"}, 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        check({name, " outs_held"}, 32'(obs), 32'h0);
        #2;
        reset = 1'b0;
        #1;
        e = '0; e.ire = 1'b1;
        check({name, " fetch_after"}, 32'(obs), 32'(e));
        imem_rdy = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        cls_e c;
        reset    = 1'b1;
        instr    = 32'h00221820;
        zero     = 1'b0;
        imem_rdy = 1'b1;
        dm_rdy   = 1'b1;
        #2;
        check("reset_init", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        do_reset("rst0");

        run_instr("add",      C_ADD, 32'h00221820, 0, 0);
        run_instr("lw_wait3", C_LW,  32'h8C220004, 0, 3);
        run_instr("sw",       C_SW,  32'hAC220004, 0, 0);
        run_instr("jal",      C_JAL, 32'h0C000010, 0, 0);
        run_instr("beq",      C_BEQ, 32'h10220003, 0, 0);
        run_instr("jr",       C_JR,  32'h03E00008, 0, 0);
        run_instr("nop",      C_NOP, 32'h00000000, 0, 0);
        run_instr("ori",      C_ORI, 32'h34220055, 0, 0);
        run_instr("lui",      C_LUI, 32'h3C011234, 0, 0);
        run_instr("sub_fw2",  C_SUB, 32'h00221822, 2, 0);
        run_instr("sw_wait2", C_SW,  32'hAC220004, 1, 2);
        run_instr("ill",      C_ILL, 32'hFC000000, 0, 0);
`ifdef MCTRL_ILLEGAL_TRAP_EN
        do_reset("rst_trap");
`endif

        // Reset while lw is waiting in MEM, then a clean add
        instr = 32'h8C220004;
        build(C_LW, 0, 5);
        run_trace("lw_cut", -2, 4);
        do_reset("rst_mem");
        run_instr("add_after_rst", C_ADD, 32'h00221820, 0, 0);

        for (int n = 0; n < 120; n++) begin
            c = cls_e'($urandom_range(0, 10));
            run_instr($sformatf("rnd%0d_%s", n, c.name()), c, make_instr(c),
                      $urandom_range(0, 2), $urandom_range(0, 3));
`ifdef MCTRL_ILLEGAL_TRAP_EN
            if (c == C_ILL) do_reset($sformatf("rnd%0d_rst", n));
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
